// File: rtl/seq_counter_ctrl_if.sv
// seq_counter_ctrl_if
//   Groups the configuration, control and status signals of seq_counter_ctrl.
//   master : configuration/control side (drives cfg_*, start_state, steps,
//            start, stop; observes busy, done, wrap, out, lockup)
//   slave  : the sequencing controller itself
//   Parameters WIDTH (counter width) and STEPS_W (step-count width) must match
//   the controller instance.
interface seq_counter_ctrl_if #(
   parameter int WIDTH   = 3,
   parameter int STEPS_W = 8
);
   logic               cfg_we;
   logic [WIDTH-1:0]   cfg_addr;
   logic [WIDTH-1:0]   cfg_data;
   logic [WIDTH-1:0]   start_state;
   logic [STEPS_W-1:0] steps;
   logic               start;
   logic               stop;
   logic               busy;
   logic               done;
   logic               wrap;
   logic [WIDTH-1:0]   out;
   logic               lockup;

   modport master (
      output cfg_we, cfg_addr, cfg_data, start_state, steps, start, stop,
      input  busy, done, wrap, out, lockup
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_data, start_state, steps, start, stop,
      output busy, done, wrap, out, lockup
   );
endinterface

// File: rtl/seq_counter_ctrl.sv
// seq_counter_ctrl
//   Programmable sequencing controller. A 2^WIDTH-entry next-state table maps
//   each counter value to its successor; a start request loads start_state and
//   steps the counter through 'steps' transitions, reporting done and wrap.
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous, active-high; also restores the up-count table
//   bus    : seq_counter_ctrl_if.slave
//            cfg_we/cfg_addr/cfg_data : table write (ignored while running)
//            start_state/steps/start  : run request (start level-sampled)
//            stop                     : abort a run
//            busy/done/wrap/out       : registered status and counter value
//            lockup                   : sticky loop-without-start detector
// Build option:
//   SEQ_COUNTER_CTRL_LOCKUP_DET_EN : builds the lockup detector; otherwise
//   lockup is tied low.
module seq_counter_ctrl #(
   parameter int WIDTH   = 3,
   parameter int STEPS_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   seq_counter_ctrl_if.slave  bus
);

   localparam int DEPTH = 2 ** WIDTH;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t             state, state_nxt;
   logic [WIDTH-1:0]   tbl [DEPTH];
   logic [WIDTH-1:0]   out_q, out_nxt;
   logic [WIDTH-1:0]   anchor_q, anchor_nxt;   // start_state captured at start
   logic [WIDTH-1:0]   succ;
   logic [STEPS_W-1:0] rem_q, rem_nxt;
   logic               busy_q, done_q, wrap_q, wrap_nxt;
   logic               cfg_ok;

   assign succ   = tbl[out_q];
   assign cfg_ok = (state != RUN);

   always_comb begin
      state_nxt  = state;
      out_nxt    = out_q;
      rem_nxt    = rem_q;
      anchor_nxt = anchor_q;
      wrap_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               out_nxt    = bus.start_state;
               anchor_nxt = bus.start_state;
               rem_nxt    = bus.steps;
               state_nxt  = (bus.steps != '0) ? RUN : DONE;
            end
         end
         RUN: begin
            if (bus.stop) begin
               state_nxt = IDLE;
            end else begin
               out_nxt  = succ;
               rem_nxt  = rem_q - STEPS_W'(1);
               wrap_nxt = (succ == anchor_q);
               if (rem_q == STEPS_W'(1)) begin
                  state_nxt = DONE;
               end
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_q    <= '0;
         anchor_q <= '0;
         rem_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         wrap_q   <= 1'b0;
      end else begin
         out_q    <= out_nxt;
         anchor_q <= anchor_nxt;
         rem_q    <= rem_nxt;
         busy_q   <= (state_nxt == RUN);
         done_q   <= (state_nxt == DONE);
         wrap_q   <= wrap_nxt;
      end
   end

   // Writes in the start cycle land before the first step reads the table.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            tbl[i] <= WIDTH'(i + 1);
         end
      end else if (cfg_ok && bus.cfg_we) begin
         tbl[bus.cfg_addr] <= bus.cfg_data;
      end
   end

   assign bus.out  = out_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.wrap = wrap_q;

`ifdef SEQ_COUNTER_CTRL_LOCKUP_DET_EN
   localparam logic [WIDTH:0] LK_LIMIT = (WIDTH + 1)'(DEPTH);

   logic [WIDTH:0] lk_cnt;
   logic           lockup_q;
   logic           start_acc, step;

   assign start_acc = (state == IDLE) && bus.start;
   assign step      = (state == RUN) && !bus.stop;

   // Counts steps since the start state was last visited; saturates once
   // the flag is set so it cannot roll over and re-trigger.
   always_ff @(posedge clk) begin
      if (reset) begin
         lk_cnt   <= '0;
         lockup_q <= 1'b0;
      end else if (start_acc) begin
         lk_cnt   <= '0;
         lockup_q <= 1'b0;
      end else if (step) begin
         if (wrap_nxt) begin
            lk_cnt <= '0;
         end else begin
            if (lk_cnt != LK_LIMIT) begin
               lk_cnt <= lk_cnt + (WIDTH + 1)'(1);
            end
            if (lk_cnt == LK_LIMIT - (WIDTH + 1)'(1)) begin
               lockup_q <= 1'b1;
            end
         end
      end
   end

   assign bus.lockup = lockup_q;
`else
   assign bus.lockup = 1'b0;
`endif

endmodule

// File: tb/tb_seq_counter_ctrl.sv
// tb_seq_counter_ctrl
//   Self-checking bench for seq_counter_ctrl. A bench-side copy of the
//   successor table predicts each run step by step; outputs are sampled on the
//   falling edge and compared as {out, busy, done, wrap, lockup}.
module tb_seq_counter_ctrl;

   localparam int W  = 3;
   localparam int SW = 8;
   localparam int D  = 8;

`ifdef SEQ_COUNTER_CTRL_LOCKUP_DET_EN
   localparam bit LK_EN = 1'b1;
`else
   localparam bit LK_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   seq_counter_ctrl_if #(.WIDTH(W), .STEPS_W(SW)) bus ();

   seq_counter_ctrl #(.WIDTH(W), .STEPS_W(SW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   logic [W-1:0] mtab [D];

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic model_reset_tab();
      for (int i = 0; i < D; i++) mtab[i] = W'(i + 1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      model_reset_tab();
   endtask

   task automatic write_cfg(input logic [W-1:0] a, input logic [W-1:0] d);
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = a;
      bus.cfg_data = d;
      tick();
      bus.cfg_we   = 1'b0;
      mtab[a]      = d;
   endtask

   task automatic pulse_start(input logic [W-1:0] s, input logic [SW-1:0] n);
      bus.start_state = s;
      bus.steps       = n;
      bus.start       = 1'b1;
      tick();
      bus.start       = 1'b0;
   endtask

   task automatic test_reset();
      logic [W+3:0] got, exp;
      do_reset();
      got = {bus.out, bus.busy, bus.done, bus.wrap, bus.lockup};
      exp = {W'(0), 4'b0000};
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL reset_state: got %b want %b", got, exp);
      end
   endtask

   task automatic test_upcount();
      logic [W+3:0] got, exp;
      pulse_start(W'(0), SW'(3));
      got = {bus.out, bus.busy, bus.done, bus.wrap, bus.lockup};
      exp = {W'(0), 4'b1000};
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL upcount_start: got %b want %b", got, exp);
      end
      for (int k = 1; k <= 4; k++) begin
         tick();
         got = {bus.out, bus.busy, bus.done, bus.wrap, bus.lockup};
         exp = {W'(k > 3 ? 3 : k), (k < 3), (k == 3), 2'b00};
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL upcount_step%0d: got %b want %b", k, got, exp);
         end
      end
   endtask

   task automatic test_custom_cycle();
      logic [W+3:0] got, exp;
      logic [W-1:0] cur;
      write_cfg(W'(0), W'(3));
      write_cfg(W'(3), W'(5));
      write_cfg(W'(5), W'(6));
      write_cfg(W'(6), W'(0));
      pulse_start(W'(0), SW'(8));
      cur = W'(0);
      for (int k = 1; k <= 8; k++) begin
         tick();
         cur = mtab[cur];
         got = {bus.out, bus.busy, bus.done, bus.wrap, bus.lockup};
         exp = {cur, (k < 8), (k == 8), (cur == W'(0)), 1'b0};
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL cycle_step%0d: got %b want %b", k, got, exp);
         end
      end
      tick();
   endtask

   task automatic test_stop();
      logic [W+3:0] got, exp;
      pulse_start(W'(0), SW'(6));
      tick();
      tick();
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
      for (int k = 0; k < 3; k++) begin
         got = {bus.out, bus.busy, bus.done, bus.wrap, bus.lockup};
         exp = {W'(5), 4'b0000};
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL stop_hold%0d: got %b want %b", k, got, exp);
         end
         tick();
      end
      pulse_start(W'(0), SW'(2));
      tick();
      got = {bus.out, bus.busy, bus.done, bus.wrap, bus.lockup};
      exp = {W'(3), 4'b1000};
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL stop_restart: got %b want %b", got, exp);
      end
      tick();
      tick();
   endtask

   task automatic test_cfg_in_run();
      logic [W+3:0] got, exp;
      pulse_start(W'(0), SW'(3));
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = W'(0);
      bus.cfg_data = W'(7);
      tick();
      tick();
      tick();
      bus.cfg_we = 1'b0;
      tick();
      pulse_start(W'(0), SW'(1));
      tick();
      got = {bus.out, bus.busy, bus.done, bus.wrap, bus.lockup};
      exp = {W'(3), 4'b0100};
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL cfg_in_run_dropped: got %b want %b", got, exp);
      end
      tick();
   endtask

   task automatic test_zero_steps();
      logic [W+3:0] got, exp;
      pulse_start(W'(5), SW'(0));
      got = {bus.out, bus.busy, bus.done, bus.wrap, bus.lockup};
      exp = {W'(5), 4'b0100};
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL zero_steps_done: got %b want %b", got, exp);
      end
      tick();
      got = {bus.out, bus.busy, bus.done, bus.wrap, bus.lockup};
      exp = {W'(5), 4'b0000};
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL zero_steps_after: got %b want %b", got, exp);
      end
   endtask

   task automatic test_lockup();
      logic [W+3:0] got, exp;
      logic [W-1:0] cur;
      do_reset();
      write_cfg(W'(2), W'(1));
      pulse_start(W'(0), SW'(20));
      cur = W'(0);
      for (int k = 1; k <= 20; k++) begin
         tick();
         cur = mtab[cur];
         got = {bus.out, bus.busy, bus.done, bus.wrap, bus.lockup};
         exp = {cur, (k < 20), (k == 20), 1'b0, LK_EN && (k >= 8)};
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL lockup_step%0d: got %b want %b", k, got, exp);
         end
      end
      tick();
      vectors++;
      if (bus.lockup !== LK_EN) begin
         miscompares++;
         $display("FAIL lockup_sticky: got %b want %b", bus.lockup, LK_EN);
      end
      pulse_start(W'(0), SW'(1));
      vectors++;
      if (bus.lockup !== 1'b0) begin
         miscompares++;
         $display("FAIL lockup_clear: got %b want 0", bus.lockup);
      end
      tick();
      tick();
   endtask

   task automatic test_reset_midrun();
      logic [W+3:0] got, exp;
      write_cfg(W'(0), W'(4));
      pulse_start(W'(0), SW'(5));
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      model_reset_tab();
      got = {bus.out, bus.busy, bus.done, bus.wrap, bus.lockup};
      exp = {W'(0), 4'b0000};
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL reset_midrun_state: got %b want %b", got, exp);
      end
      pulse_start(W'(0), SW'(1));
      tick();
      got = {bus.out, bus.busy, bus.done, bus.wrap, bus.lockup};
      exp = {W'(1), 4'b0100};
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL reset_midrun_table: got %b want %b", got, exp);
      end
      tick();
   endtask

   task automatic test_random();
      logic [W+3:0] got, exp;
      logic [W-1:0] s, cur;
      int           n, stop_at, last;
      bit           lk, stopped;
      for (int it = 0; it < 30; it++) begin
         for (int i = 0; i < D; i++) write_cfg(W'(i), W'($urandom));
         s       = W'($urandom);
         n       = int'($urandom_range(0, 20));
         stop_at = ($urandom_range(0, 3) == 0 && n > 0) ? int'($urandom_range(1, n)) : 0;
         // optional table write in the same cycle as the start request
         bus.cfg_we   = 1'($urandom_range(0, 1));
         bus.cfg_addr = W'($urandom);
         bus.cfg_data = W'($urandom);
         if (bus.cfg_we) mtab[bus.cfg_addr] = bus.cfg_data;
         pulse_start(s, SW'(n));
         bus.cfg_we = 1'b0;
         got = {bus.out, bus.busy, bus.done, bus.wrap, bus.lockup};
         exp = {s, (n != 0), (n == 0), 2'b00};
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL rand%0d_start: got %b want %b", it, got, exp);
         end
         cur     = s;
         last    = 0;
         lk      = 1'b0;
         stopped = 1'b0;
         for (int k = 1; k <= n && !stopped; k++) begin
            bus.stop     = (k == stop_at);
            bus.cfg_we   = 1'($urandom_range(0, 1));
            bus.cfg_addr = W'($urandom);
            bus.cfg_data = W'($urandom);
            tick();
            bus.cfg_we = 1'b0;
            if (bus.stop) begin
               bus.stop = 1'b0;
               stopped  = 1'b1;
               exp = {cur, 3'b000, lk};
            end else begin
               cur = mtab[cur];
               if (cur == s) last = k;
               if (LK_EN && (k - last >= D)) lk = 1'b1;
               exp = {cur, (k < n), (k == n), (cur == s), lk};
            end
            got = {bus.out, bus.busy, bus.done, bus.wrap, bus.lockup};
            vectors++;
            if (got !== exp) begin
               miscompares++;
               $display("FAIL rand%0d_step%0d: got %b want %b", it, k, got, exp);
            end
         end
         tick();
         vectors++;
         if ({bus.busy, bus.done, bus.wrap} !== 3'b000) begin
            miscompares++;
            $display("FAIL rand%0d_idle: got %b want 000", it, {bus.busy, bus.done, bus.wrap});
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset           = 1'b1;
      bus.cfg_we      = 1'b0;
      bus.cfg_addr    = '0;
      bus.cfg_data    = '0;
      bus.start_state = '0;
      bus.steps       = '0;
      bus.start       = 1'b0;
      bus.stop        = 1'b0;
      test_reset();
      test_upcount();
      test_custom_cycle();
      test_stop();
      test_cfg_in_run();
      test_zero_steps();
      test_lockup();
      test_reset_midrun();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
